// File: rtl/bit_selection_pkg.sv
// Shared helpers for the bit-window selector: offset width and the
// zero-fill window extraction.
package bit_selection_pkg;

  // Widest input bus the extraction helper handles.
  localparam int unsigned SEL_MAX_W = 256;

  // One extra bit lets cmd + SHIFT_BASE be formed without wrapping.
  function automatic int unsigned off_width(input int unsigned cmd_w);
    return cmd_w + 1;
  endfunction

  // Callers zero-extend data above their MSB, so a plain right shift
  // yields the zero-filled window; offsets past the bus give all zero.
  function automatic logic [SEL_MAX_W-1:0] sel_window(
    input logic [SEL_MAX_W-1:0] data,
    input int unsigned          off
  );
    if (off >= SEL_MAX_W) return '0;
    return data >> off;
  endfunction

endpackage

// File: rtl/bit_selection_pipe_stage.sv
// One valid/ready register slice; holds its payload while downstream stalls.
module bit_selection_pipe_stage
  import bit_selection_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat whenever the slot is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bit_selection_window_pipe.sv
// Pipelined bit-window selector: S1 registers data and offset, the shift
// mux sits between S1 and S2, S2 registers the selected window.
// Optional delivered-beat counter: define BIT_SELECTION_BEAT_COUNT_EN.
module bit_selection_window_pipe
  import bit_selection_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned OUT_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int unsigned COMMAND_WIDTH  = $clog2(DATA_WIDTH) - 1,
  parameter int unsigned SHIFT_BASE     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd,
  input  logic                      i_en,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OUT_DATA_WIDTH-1:0] o_data_bus,
  output logic [31:0]               o_beat_count
);

  localparam int unsigned OFF_W = off_width(COMMAND_WIDTH);
  localparam int unsigned S1_W  = DATA_WIDTH + OFF_W;

  logic [OFF_W-1:0]          in_off;
  logic                      s1_in_ready;
  logic                      s1_valid;
  logic [S1_W-1:0]           s1_q;
  logic [DATA_WIDTH-1:0]     s1_data;
  logic [OFF_W-1:0]          s1_off;
  logic                      s2_in_ready;
  logic [OUT_DATA_WIDTH-1:0] sel;

  assign in_off  = OFF_W'({1'b0, i_cmd}) + OFF_W'(SHIFT_BASE);
  assign o_ready = !rst && i_en && s1_in_ready;

  bit_selection_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i_valid && o_ready),
    .in_ready  (s1_in_ready),
    .in_data   ({i_data_bus, in_off}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  assign {s1_data, s1_off} = s1_q;
  assign sel = OUT_DATA_WIDTH'(sel_window(SEL_MAX_W'(s1_data), 32'(s1_off)));

  bit_selection_pipe_stage #(.WIDTH(OUT_DATA_WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (sel),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_data  (o_data_bus)
  );

`ifdef BIT_SELECTION_BEAT_COUNT_EN
  logic [31:0] beat_count;

  // Count output transfers; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) beat_count <= '0;
    else if (o_valid && i_ready) beat_count <= beat_count + 32'd1;
  end

  assign o_beat_count = beat_count;
`else
  assign o_beat_count = '0;
`endif

endmodule

// File: tb/tb_bit_selection_window_pipe.sv
// Bench for bit_selection_window_pipe: directed table, hand-written
// multi-cycle sequences and a randomized scoreboard run.
module tb_bit_selection_window_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_en, i_ready;
  logic [15:0] i_data_bus;
  logic [2:0]  cmd_a;
  logic [3:0]  cmd_b;
  logic        o_ready_a, o_valid_a, o_ready_b, o_valid_b;
  logic [7:0]  o_data_a, o_data_b;
  logic [31:0] cnt_a, cnt_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bit_selection_window_pipe dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_data_bus(i_data_bus), .i_cmd(cmd_a), .i_en(i_en),
    .o_valid(o_valid_a), .i_ready(i_ready), .o_data_bus(o_data_a),
    .o_beat_count(cnt_a)
  );

  bit_selection_window_pipe #(
    .DATA_WIDTH(16), .OUT_DATA_WIDTH(8), .COMMAND_WIDTH(4), .SHIFT_BASE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_data_bus(i_data_bus), .i_cmd(cmd_b), .i_en(i_en),
    .o_valid(o_valid_b), .i_ready(i_ready), .o_data_bus(o_data_b),
    .o_beat_count(cnt_b)
  );

  // Reference: output bit k is input bit off+k when that exists, else 0.
  function automatic logic [7:0] model_sel(input logic [15:0] d, input int off);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (off + k < 16) r[k] = d[off+k];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard state for randomized traffic on dut_a.
  logic [7:0] sb[$];
  bit         prev_stall;
  logic [7:0] prev_data;
  int         delivered;

  task automatic rcycle(input logic v, input logic en, input logic rdy,
                        input logic [15:0] d, input logic [2:0] c);
    i_valid = v; i_en = en; i_ready = rdy; i_data_bus = d;
    cmd_a = c; cmd_b = {1'b0, c};
    #1;
    check("rnd_o_ready", 32'(o_ready_a), 32'(en && (sb.size() < 2 || rdy)));
    if (prev_stall) begin
      check("rnd_hold_valid", 32'(o_valid_a), 32'd1);
      check("rnd_hold_data", 32'(o_data_a), 32'(prev_data));
    end
    if (o_valid_a && rdy) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rnd_spurious: got beat 0x%0h expected none", o_data_a);
      end else begin
        check("rnd_data", 32'(o_data_a), 32'(sb.pop_front()));
      end
      delivered++;
    end
    if (v && o_ready_a) sb.push_back(model_sel(d, int'(c) + 1));
    prev_stall = o_valid_a && !rdy;
    prev_data  = o_data_a;
    step();
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  cmd;
    bit          use_b;
    logic [7:0]  exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[7];
    vec_t       vv;
    logic [7:0] got[$];
    logic [7:0] bp_exp[4];
    logic       ov;
    logic [7:0] od;
    int         sent;
    int         exp_cnt;

    tbl[0] = '{16'hA442, 4'd0,  1'b0, 8'h21};
    tbl[1] = '{16'hA442, 4'd1,  1'b0, 8'h10};
    tbl[2] = '{16'hA442, 4'd2,  1'b0, 8'h88};
    tbl[3] = '{16'hA442, 4'd3,  1'b0, 8'h44};
    tbl[4] = '{16'hA442, 4'd7,  1'b0, 8'hA4};
    tbl[5] = '{16'hA442, 4'd12, 1'b1, 8'h05};
    tbl[6] = '{16'hA442, 4'd15, 1'b1, 8'h00};
    bp_exp[0] = 8'h21; bp_exp[1] = 8'h10; bp_exp[2] = 8'h88; bp_exp[3] = 8'h44;

    // Reset state.
    rst = 1'b1; i_valid = 1'b0; i_en = 1'b1; i_ready = 1'b1;
    i_data_bus = 16'hA442; cmd_a = '0; cmd_b = '0;
    #1;
    check("rst_o_ready", 32'(o_ready_a), 32'd0);
    step();
    step();
    check("rst_o_valid", 32'(o_valid_a), 32'd0);
    check("rst_o_data", 32'(o_data_a), 32'd0);
    check("rst_count", cnt_a, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_o_ready", 32'(o_ready_a), 32'd1);

    // Directed table: single beats, exact two-cycle latency.
    for (int i = 0; i < 7; i++) begin
      vv = tbl[i];
      i_data_bus = vv.data; cmd_b = vv.cmd; cmd_a = vv.cmd[2:0];
      i_valid = 1'b1; i_en = 1'b1; i_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_accept", i), 32'(vv.use_b ? o_ready_b : o_ready_a), 32'd1);
      step();
      i_valid = 1'b0;
      #1;
      ov = vv.use_b ? o_valid_b : o_valid_a;
      check($sformatf("tbl%0d_early", i), 32'(ov), 32'd0);
      step();
      ov = vv.use_b ? o_valid_b : o_valid_a;
      od = vv.use_b ? o_data_b : o_data_a;
      check($sformatf("tbl%0d_valid", i), 32'(ov), 32'd1);
      check($sformatf("tbl%0d_data", i), 32'(od), 32'(vv.exp));
      step();
    end

    // Backpressure: 4 back-to-back beats, i_ready low in cycles 3..6.
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      i_valid = (sent < 4); cmd_a = sent[2:0]; cmd_b = sent[3:0];
      i_data_bus = 16'hA442; i_en = 1'b1;
      i_ready = !(c >= 3 && c <= 6);
      #1;
      if (c >= 3 && c <= 6) begin
        check("bp_o_ready_low", 32'(o_ready_a), 32'd0);
        check("bp_hold_valid", 32'(o_valid_a), 32'd1);
        check("bp_hold_data", 32'(o_data_a), 32'h10);
      end
      if (o_valid_a && i_ready) got.push_back(o_data_a);
      if (i_valid && o_ready_a) sent++;
      step();
    end
    check("bp_beats", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("bp_order%0d", i), 32'(got[i]), 32'(bp_exp[i]));
    end

    // i_en low: beat in flight delivers, nothing new accepted.
    i_en = 1'b1; i_valid = 1'b1; i_ready = 1'b1; cmd_a = 3'd1; cmd_b = 4'd1;
    #1;
    check("en_accept", 32'(o_ready_a), 32'd1);
    step();
    for (int c = 1; c <= 3; c++) begin
      i_en = 1'b0; i_valid = 1'b1; cmd_a = 3'd0;
      #1;
      check("en_o_ready", 32'(o_ready_a), 32'd0);
      check("en_o_valid", 32'(o_valid_a), 32'(c == 2));
      if (c == 2) check("en_inflight_data", 32'(o_data_a), 32'h10);
      step();
    end
    i_en = 1'b1; i_valid = 1'b0;
    #1;
    check("en_no_extra", 32'(o_valid_a), 32'd0);
    step();

    // Reset with two beats in flight.
    i_valid = 1'b1; cmd_a = 3'd2; step();
    cmd_a = 3'd3; step();
    i_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst_o_ready", 32'(o_ready_a), 32'd0);
    step();
    rst = 1'b0; i_valid = 1'b1; cmd_a = 3'd0;
    #1;
    check("midrst_o_valid", 32'(o_valid_a), 32'd0);
    check("midrst_o_data", 32'(o_data_a), 32'd0);
    check("midrst_accept", 32'(o_ready_a), 32'd1);
    step();
    i_valid = 1'b0;
    #1;
    check("midrst_early", 32'(o_valid_a), 32'd0);
    step();
    check("midrst_valid", 32'(o_valid_a), 32'd1);
    check("midrst_data", 32'(o_data_a), 32'h21);
    step();
    step();

    // Beat counter: 5 beats, one held for 3 stalled cycles.
    do_reset();
    sent = 0; delivered = 0;
    for (int c = 0; c < 20; c++) begin
      i_valid = (sent < 5); cmd_a = sent[2:0]; i_en = 1'b1;
      i_ready = !(c >= 4 && c <= 6);
      #1;
      if (o_valid_a && i_ready) delivered++;
      if (i_valid && o_ready_a) sent++;
      step();
    end
    check("cnt_delivered", 32'(delivered), 32'd5);
`ifdef BIT_SELECTION_BEAT_COUNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    check("cnt_value", cnt_a, 32'(exp_cnt));

    // Randomized traffic against the scoreboard.
    do_reset();
    sb.delete(); prev_stall = 1'b0; delivered = 0;
    for (int n = 0; n < 400; n++) begin
      rcycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 2) != 0, 16'($urandom), 3'($urandom));
    end
    for (int n = 0; n < 12 && sb.size() > 0; n++) begin
      rcycle(1'b0, 1'b1, 1'b1, 16'h0, 3'd0);
    end
    check("rnd_drained", 32'(sb.size()), 32'd0);
`ifdef BIT_SELECTION_BEAT_COUNT_EN
    exp_cnt = delivered;
`else
    exp_cnt = 0;
`endif
    check("rnd_count", cnt_a, 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
